message_receiver: RTL and testbench

- Receive-side counterpart of the sensor messaging path.
- Pulls 16-bit words from the SPI receive interface, hunts for a sync word, then reassembles the following payload words into one frame of 2*SENSORS*BITWIDTH bits.
- Presents the frame with a valid/ack handshake to downstream logic.
- Drops a partial frame on inter-word timeout and reports the error.

---
 rtl/message_receiver_if.sv | 34 +++
 rtl/message_receiver.sv | 103 ++++++++++
 tb/tb_message_receiver.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/message_receiver_if.sv
// rtl/message_receiver_if.sv - SPI-word input and frame-output bundle for message_receiver
// Purpose: groups the SPI receive handshake and the frame handshake.
// Signals:
//   spi_in       [15:0]      received SPI word
//   spi_rx_ready             a received word is pending
//   read                     one-cycle consume pulse back to SPI side
//   frame_data   [FRAME_W-1:0] assembled frame
//   frame_valid              frame_data holds a complete frame
//   frame_ack                consumer takes the frame
//   timeout_err              one-cycle pulse on partial-frame drop
//   err_count    [7:0]       wrapping count of drops
// Modports: slave = receiver side, master = SPI source / frame consumer side.
interface message_receiver_if #(
  parameter int FRAME_W = 64
);
  logic [15:0]        spi_in;
  logic               spi_rx_ready;
  logic               read;
  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic               frame_ack;
  logic               timeout_err;
  logic [7:0]         err_count;

  modport slave (
    input  spi_in, spi_rx_ready, frame_ack,
    output read, frame_data, frame_valid, timeout_err, err_count
  );

  modport master (
    output spi_in, spi_rx_ready, frame_ack,
    input  read, frame_data, frame_valid, timeout_err, err_count
  );
endinterface

// File: rtl/message_receiver.sv
// rtl/message_receiver.sv - sync-word framed SPI word reassembler with timeout drop
// Purpose: hunts for SYNC_WORD, collects N = 2*SENSORS*BITWIDTH/16 payload words
// into one frame, holds it under a valid/ack handshake, drops partial frames after
// TIMEOUT idle cycles.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  message_receiver_if.slave (SPI word input, frame output, error reporting)
module message_receiver #(
  parameter int          SENSORS   = 1,
  parameter int          BITWIDTH  = 32,
  parameter logic [15:0] SYNC_WORD = 16'hA5A5,
  parameter int          TIMEOUT   = 1024
) (
  input logic               clk,
  input logic               rst,
  message_receiver_if.slave bus
);
  localparam int FRAME_W = 2 * SENSORS * BITWIDTH;
  localparam int N       = FRAME_W / 16;
  localparam int WCW     = $clog2(N + 1);
  localparam int ICW     = $clog2(TIMEOUT + 1);

  localparam logic [WCW-1:0] LAST_WORD = WCW'(N - 1);
  localparam logic [ICW-1:0] IDLE_MAX  = ICW'(TIMEOUT);

  typedef enum logic [1:0] {HUNT, COLLECT, HOLD} state_t;

  state_t             state;
  logic               read_q;
  logic               frame_valid_q;
  logic               timeout_err_q;
  logic [7:0]         err_count_q;
  logic [FRAME_W-1:0] frame_data_q;
  logic [WCW-1:0]     word_cnt;
  logic [ICW-1:0]     idle_cnt;
  logic               accept;

  // read_q blocks a second accept on the word still presented during the consume pulse
  assign accept = bus.spi_rx_ready && !read_q && (state != HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= HUNT;
      read_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      err_count_q   <= 8'd0;
      frame_data_q  <= '0;
      word_cnt      <= '0;
      idle_cnt      <= '0;
    end else begin
      read_q        <= accept;
      timeout_err_q <= 1'b0;
      case (state)
        HUNT: begin
          if (accept && (bus.spi_in == SYNC_WORD)) begin
            state    <= COLLECT;
            word_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        COLLECT: begin
          // an accept on the threshold cycle takes priority over the drop
          if (accept) begin
            for (int k = 0; k < N; k++) begin
              if (word_cnt == WCW'(k)) frame_data_q[16*k +: 16] <= bus.spi_in;
            end
            word_cnt <= word_cnt + WCW'(1);
            idle_cnt <= '0;
            if (word_cnt == LAST_WORD) begin
              state         <= HOLD;
              frame_valid_q <= 1'b1;
            end
          end else if (idle_cnt == IDLE_MAX) begin
            timeout_err_q <= 1'b1;
            err_count_q   <= err_count_q + 8'd1;
            word_cnt      <= '0;
            idle_cnt      <= '0;
            state         <= HUNT;
          end else begin
            idle_cnt <= idle_cnt + ICW'(1);
          end
        end
        HOLD: begin
          // idle counter frozen here: a slow consumer never triggers a drop
          if (bus.frame_ack) begin
            frame_valid_q <= 1'b0;
            state         <= HUNT;
            word_cnt      <= '0;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign bus.read        = read_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_data  = frame_data_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_message_receiver.sv
// tb/tb_message_receiver.sv - scoreboard bench for message_receiver
module tb_message_receiver;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;

  message_receiver_if #(.FRAME_W(64)) bus ();

  message_receiver #(
    .SENSORS(1), .BITWIDTH(32), .SYNC_WORD(16'hA5A5), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  int  frames_seen = 0;
  int  read_cnt    = 0;
  int  to_cnt      = 0;
  bit  ack_en      = 1'b1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // consumer + event counters, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.read === 1'b1) read_cnt++;
    if (bus.timeout_err === 1'b1) to_cnt++;
    if (!rst) begin
      bus.frame_ack = 1'b0;
    end else if (bus.frame_ack) begin
      bus.frame_ack = 1'b0;
      check("valid_low_after_ack", {63'd0, bus.frame_valid}, 64'd0);
    end else if (bus.frame_valid && ack_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 64'd1, 64'd0);
      end else begin
        check("frame_data", bus.frame_data, exp_q.pop_front());
      end
      frames_seen++;
      bus.frame_ack = 1'b1;
    end
  end

  task automatic send_word(input logic [15:0] w);
    bit got = 1'b0;
    bus.spi_in       = w;
    bus.spi_rx_ready = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.read) got = 1'b1;
    end
    bus.spi_rx_ready = 1'b0;
    if (!got) check("send_word_stall", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input logic [15:0] w0, w1, w2, w3);
    exp_q.push_back({w3, w2, w1, w0});
    send_word(16'hA5A5);
    send_word(w0);
    send_word(w1);
    send_word(w2);
    send_word(w3);
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 100 && frames_seen < n; i++) @(negedge clk);
    if (frames_seen < n) check("frame_wait", 64'(frames_seen), 64'(n));
    @(negedge clk);
  endtask

  task automatic wait_drop(output bit seen);
    int start = to_cnt;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (to_cnt != start) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int r0;
    int t0;
    int cyc;
    bit seen;
    bit got;
    logic [63:0] held;

    rst              = 1'b0;
    bus.spi_in       = 16'h0;
    bus.spi_rx_ready = 1'b0;
    bus.frame_ack    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_read",        {63'd0, bus.read},        64'd0);
    check("rst_frame_valid", {63'd0, bus.frame_valid}, 64'd0);
    check("rst_timeout_err", {63'd0, bus.timeout_err}, 64'd0);
    check("rst_err_count",   {56'd0, bus.err_count},   64'd0);
    check("rst_frame_data",  bus.frame_data,           64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // basic frame
    r0 = read_cnt;
    exp_q.push_back(64'h4444_3333_2222_1111);
    send_word(16'hA5A5);
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    send_word(16'h4444);
    check("basic_latency_valid", {63'd0, bus.frame_valid}, 64'd1);
    wait_frames(1);
    check("basic_read_pulses", 64'(read_cnt - r0), 64'd5);
    check("basic_valid_after", {63'd0, bus.frame_valid}, 64'd0);

    // hunt discards non-sync words but still consumes them
    r0 = read_cnt;
    exp_q.push_back(64'h0004_0003_0002_0001);
    send_word(16'h0000);
    send_word(16'hBEEF);
    send_word(16'hA5A5);
    send_word(16'h0001);
    send_word(16'h0002);
    send_word(16'h0003);
    send_word(16'h0004);
    wait_frames(2);
    check("hunt_read_pulses", 64'(read_cnt - r0), 64'd7);

    // sync word inside payload is data
    send_frame(16'hA5A5, 16'h0001, 16'hA5A5, 16'h0002);
    wait_frames(3);
    check("sync_payload_no_valid", {63'd0, bus.frame_valid}, 64'd0);

    // backpressure in HOLD
    ack_en = 1'b0;
    send_frame(16'hC001, 16'hC002, 16'hC003, 16'hC004);
    bus.spi_in       = 16'hA5A5;
    bus.spi_rx_ready = 1'b1;
    @(negedge clk);
    r0   = read_cnt;
    t0   = to_cnt;
    held = 64'hC004_C003_C002_C001;
    repeat (50) begin
      @(negedge clk);
      if (bus.frame_data !== held) held = 64'hDEAD_DEAD_DEAD_DEAD;
    end
    check("bp_no_read",      64'(read_cnt - r0), 64'd0);
    check("bp_no_timeout",   64'(to_cnt - t0),   64'd0);
    check("bp_data_stable",  held,               64'hC004_C003_C002_C001);
    check("bp_valid_held",   {63'd0, bus.frame_valid}, 64'd1);
    @(posedge clk);
    ack_en = 1'b1;
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.read) got = 1'b1;
    end
    check("bp_accept_after_ack", 64'(cyc), 64'd3);
    exp_q.push_back(64'h0008_0007_0006_0005);
    send_word(16'h0005);
    send_word(16'h0006);
    send_word(16'h0007);
    send_word(16'h0008);
    wait_frames(5);

    // timeout drop then recovery
    t0 = to_cnt;
    send_word(16'hA5A5);
    send_word(16'h1111);
    wait_drop(seen);
    check("to_seen",       {63'd0, seen},          64'd1);
    check("to_one_pulse",  64'(to_cnt - t0),       64'd1);
    check("to_err_count",  {56'd0, bus.err_count}, 64'd1);
    send_frame(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    wait_frames(6);

    // asynchronous reset mid-frame
    t0 = to_cnt;
    send_word(16'hA5A5);
    send_word(16'h1111);
    #2 rst = 1'b0;
    #1;
    check("mr_read",        {63'd0, bus.read},        64'd0);
    check("mr_frame_valid", {63'd0, bus.frame_valid}, 64'd0);
    check("mr_err_count",   {56'd0, bus.err_count},   64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("mr_no_timeout", 64'(to_cnt - t0), 64'd0);
    send_frame(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    wait_frames(7);

    // err_count wraps after 256 drops
    t0 = to_cnt;
    for (int d = 0; d < 256; d++) begin
      send_word(16'hA5A5);
      wait_drop(seen);
      if (!seen) check("wrap_drop_seen", 64'(d), 64'd256);
      if (d == 254) check("wrap_err_255", {56'd0, bus.err_count}, 64'd255);
    end
    check("wrap_drops",     64'(to_cnt - t0),       64'd256);
    check("wrap_err_count", {56'd0, bus.err_count}, 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("frames_total", 64'(frames_seen), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
